trng_noise_sequencer: RTL and testbench

Parametrised power sequencer for the avalanche noise sources feeding the TRNG. It drives the shared noise bias supply and NUM_CH per-channel noise enables. Power-up runs in order: bias first, then each enabled channel, staggered, each with a programmable settle time. A `ready` level tells the downstream sampler when all enabled sources are stable, and an idle hold timer keeps the sources powered across short gaps in demand. It sits between the TRNG CSR block (request, mask, timing values) and the analog front-end pins `noisebias_on` / `noise_on`.

---
 rtl/trng_noise_sequencer_pkg.sv | 30 +++
 rtl/trng_noise_sequencer_settle_timer.sv | 32 +++
 rtl/trng_noise_sequencer.sv | 154 +++++++++++++++
 tb/tb_trng_noise_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/trng_noise_sequencer_pkg.sv
// Shared definitions for the noise-source power sequencer: state encoding,
// channel-count ceiling and the set-bit search reused by the CSR model.
package trng_noise_sequencer_pkg;

   localparam int MAX_CH = 8;
   localparam int IDX_W  = 3;

   // Returned by next_set_bit when no set bit exists at or above start.
   localparam logic [3:0] NO_BIT = 4'd8;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_BIAS_WAIT = 3'd1,
      ST_CH_WAIT   = 3'd2,
      ST_RUN       = 3'd3,
      ST_HOLD      = 3'd4,
      ST_PWRDN     = 3'd5
   } seq_state_e;

   function automatic logic [3:0] next_set_bit(input logic [MAX_CH-1:0] mask,
                                               input logic [3:0]        start);
      logic [3:0] r;
      r = NO_BIT;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (mask[i] && (4'(i) >= start)) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/trng_noise_sequencer_settle_timer.sv
// Down-counter shared by the bias, channel and hold phases. Loads max(value,1)-1
// and saturates at zero; done is high whenever the count has reached zero.
module settle_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = (value == '0) ? '0 : value - W'(1);
      end else if (en && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/trng_noise_sequencer.sv
// Power sequencer for the TRNG avalanche noise sources: bias first, then each
// enabled channel in ascending order, with idle hold and ordered power-down.
module trng_noise_sequencer
   import trng_noise_sequencer_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int SETTLE_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic [NUM_CH-1:0]   ena_mask,
   input  logic [SETTLE_W-1:0] bias_settle,
   input  logic [SETTLE_W-1:0] ch_settle,
   input  logic [SETTLE_W-1:0] hold_cycles,
   output logic                noisebias_on,
   output logic [NUM_CH-1:0]   noise_on,
   output logic                ready,
   output logic                busy,
   output logic [2:0]          state
);

   seq_state_e          state_q, state_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [SETTLE_W-1:0] ch_settle_q, ch_settle_d;
   logic                bias_q, bias_d;
   logic [NUM_CH-1:0]   noise_q, noise_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;

   logic                tmr_load, tmr_en, tmr_done;
   logic [SETTLE_W-1:0] tmr_value;
   logic [MAX_CH-1:0]   mask_ext;
   logic [3:0]          search_start;
   logic [3:0]          next_bit;

   always_comb begin
      mask_ext = '0;
      mask_ext[NUM_CH-1:0] = mask_q;
   end

   // Leaving BIAS_WAIT searches from bit 0; inside CH_WAIT search above idx.
   assign search_start = (state_q == ST_BIAS_WAIT) ? 4'd0 : ({1'b0, idx_q} + 4'd1);
   assign next_bit     = next_set_bit(mask_ext, search_start);

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      idx_d       = idx_q;
      ch_settle_d = ch_settle_q;
      tmr_load    = 1'b0;
      tmr_en      = 1'b0;
      tmr_value   = '0;
      case (state_q)
         ST_OFF: begin
            if (req && (ena_mask != '0)) begin
               state_d     = ST_BIAS_WAIT;
               mask_d      = ena_mask;
               ch_settle_d = ch_settle;
               tmr_load    = 1'b1;
               tmr_value   = bias_settle;
            end
         end
         ST_BIAS_WAIT, ST_CH_WAIT: begin
            if (!req) begin
               state_d = ST_PWRDN;
            end else if (tmr_done) begin
               if (next_bit == NO_BIT) begin
                  state_d = ST_RUN;
               end else begin
                  state_d   = ST_CH_WAIT;
                  idx_d     = next_bit[IDX_W-1:0];
                  tmr_load  = 1'b1;
                  tmr_value = ch_settle_q;
               end
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_RUN: begin
            if (!req) begin
               state_d   = ST_HOLD;
               tmr_load  = 1'b1;
               tmr_value = hold_cycles;
            end
         end
         ST_HOLD: begin
            if (req)           state_d = ST_RUN;
            else if (tmr_done) state_d = ST_PWRDN;
            else               tmr_en  = 1'b1;
         end
         ST_PWRDN: state_d = ST_OFF;
         default:  state_d = ST_OFF;
      endcase
   end

   // Outputs are decoded from the next state so they leave the flops aligned
   // with the state register.
   always_comb begin
      bias_d  = (state_d != ST_OFF);
      busy_d  = (state_d != ST_OFF);
      ready_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
      noise_d = '0;
      case (state_d)
         ST_CH_WAIT: begin
            noise_d = noise_q;
            for (int i = 0; i < NUM_CH; i++) begin
               if (IDX_W'(i) == idx_d) noise_d[i] = 1'b1;
            end
         end
         ST_RUN, ST_HOLD: noise_d = noise_q;
         default:         noise_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_OFF;
         mask_q      <= '0;
         idx_q       <= '0;
         ch_settle_q <= '0;
         bias_q      <= 1'b0;
         noise_q     <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         idx_q       <= idx_d;
         ch_settle_q <= ch_settle_d;
         bias_q      <= bias_d;
         noise_q     <= noise_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
      end
   end

   settle_timer #(.W(SETTLE_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_value),
      .en    (tmr_en),
      .done  (tmr_done)
   );

   assign noisebias_on = bias_q;
   assign noise_on     = noise_q;
   assign ready        = ready_q;
   assign busy         = busy_q;
   assign state        = state_q;

endmodule

// File: tb/tb_trng_noise_sequencer.sv
// Bench for trng_noise_sequencer: directed vector table, corner sequences and a
// randomized run, all against a time-based behavioural model.
module tb_trng_noise_sequencer;

   localparam int NCH = 4;
   localparam int SW  = 16;

   localparam logic [2:0] S_OFF = 3'd0, S_BW = 3'd1, S_CW = 3'd2,
                          S_RUN = 3'd3, S_HOLD = 3'd4, S_PD = 3'd5;

   logic           clk = 1'b0;
   logic           rst, req;
   logic [NCH-1:0] ena_mask;
   logic [SW-1:0]  bias_settle, ch_settle, hold_cycles;
   logic           noisebias_on, ready, busy;
   logic [NCH-1:0] noise_on;
   logic [2:0]     state;

   trng_noise_sequencer #(.NUM_CH(NCH), .SETTLE_W(SW)) dut (
      .clk(clk), .rst(rst), .req(req), .ena_mask(ena_mask),
      .bias_settle(bias_settle), .ch_settle(ch_settle), .hold_cycles(hold_cycles),
      .noisebias_on(noisebias_on), .noise_on(noise_on), .ready(ready),
      .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: mode 0 off, 1 powering up, 2 powered, 3 power-down cycle.
   // t counts cycles since bias came on; n counts idle cycles in hold.
   int             m_mode = 0, m_t = 0, m_n = 0, m_B = 1, m_C = 1, m_k = 0, m_H = 1;
   logic           m_hold = 1'b0;
   logic [NCH-1:0] m_mask = '0;

   function automatic int max1(input logic [SW-1:0] v);
      return (v == '0) ? 1 : int'(v);
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0: if (req && ena_mask != '0) begin
                  m_mode = 1; m_t = 0; m_mask = ena_mask;
                  m_B = max1(bias_settle); m_C = max1(ch_settle);
                  m_k = $countones(ena_mask);
               end
            1: if (!req) m_mode = 3;
               else begin
                  m_t++;
                  if (m_t >= m_B + m_k * m_C) begin m_mode = 2; m_hold = 1'b0; end
               end
            2: if (req) m_hold = 1'b0;
               else if (!m_hold) begin m_hold = 1'b1; m_n = 0; m_H = max1(hold_cycles); end
               else begin
                  m_n++;
                  if (m_n >= m_H) m_mode = 3;
               end
            default: m_mode = 0;
         endcase
      end
   endtask

   function automatic logic [9:0] model_out();
      logic [NCH-1:0] en;
      logic [2:0]     st;
      int             rank;
      en = '0; st = S_OFF; rank = 0;
      case (m_mode)
         1: begin
            st = (m_t < m_B) ? S_BW : S_CW;
            for (int i = 0; i < NCH; i++) begin
               if (m_mask[i]) begin
                  if (m_t >= m_B + rank * m_C) en[i] = 1'b1;
                  rank++;
               end
            end
         end
         2: begin en = m_mask; st = m_hold ? S_HOLD : S_RUN; end
         3: st = S_PD;
         default: st = S_OFF;
      endcase
      return {m_mode != 0, en, m_mode == 2, m_mode != 0, st};
   endfunction

   function automatic logic [9:0] dut_out();
      return {noisebias_on, noise_on, ready, busy, state};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("model", 32'(dut_out()), 32'(model_out()));
   endtask

   typedef struct {
      int             n;
      logic           rst, req;
      logic [NCH-1:0] mask;
      logic [SW-1:0]  b, c, h;
      logic [9:0]     exp;
   } vec_t;

   function automatic logic [9:0] o(input logic eb, input logic [NCH-1:0] en,
                                    input logic er, input logic [2:0] st);
      return {eb, en, er, eb, st};
   endfunction

   vec_t vecs[15];

   task automatic set_in(input logic r, input logic q, input logic [NCH-1:0] m,
                         input int b, input int c, input int h);
      rst = r; req = q; ena_mask = m;
      bias_settle = SW'(b); ch_settle = SW'(c); hold_cycles = SW'(h);
   endtask

   initial begin
      int bias_t, ready_t, stray, seen, pd_cycles, got;
      logic [NCH-1:0] prev;
      logic [NCH-1:0] hist[$];
      set_in(1, 0, '0, 0, 0, 0);

      // Full power-up (mask 0011, bias 4, ch 3), hold/resume (hold 5), hold expiry (hold 2).
      vecs[0]  = '{2, 1, 0, 4'b0011, 4, 3, 5, o(0, 4'b0000, 0, S_OFF)};
      vecs[1]  = '{1, 0, 0, 4'b0011, 4, 3, 5, o(0, 4'b0000, 0, S_OFF)};
      vecs[2]  = '{1, 0, 1, 4'b0011, 4, 3, 5, o(1, 4'b0000, 0, S_BW)};
      vecs[3]  = '{3, 0, 1, 4'b0011, 4, 3, 5, o(1, 4'b0000, 0, S_BW)};
      vecs[4]  = '{1, 0, 1, 4'b0011, 4, 3, 5, o(1, 4'b0001, 0, S_CW)};
      vecs[5]  = '{2, 0, 1, 4'b0011, 4, 3, 5, o(1, 4'b0001, 0, S_CW)};
      vecs[6]  = '{1, 0, 1, 4'b0011, 4, 3, 5, o(1, 4'b0011, 0, S_CW)};
      vecs[7]  = '{2, 0, 1, 4'b0011, 4, 3, 5, o(1, 4'b0011, 0, S_CW)};
      vecs[8]  = '{1, 0, 1, 4'b0011, 4, 3, 5, o(1, 4'b0011, 1, S_RUN)};
      vecs[9]  = '{3, 0, 0, 4'b0011, 4, 3, 5, o(1, 4'b0011, 1, S_HOLD)};
      vecs[10] = '{1, 0, 1, 4'b0011, 4, 3, 5, o(1, 4'b0011, 1, S_RUN)};
      vecs[11] = '{1, 0, 0, 4'b0011, 4, 3, 2, o(1, 4'b0011, 1, S_HOLD)};
      vecs[12] = '{1, 0, 0, 4'b0011, 4, 3, 2, o(1, 4'b0011, 1, S_HOLD)};
      vecs[13] = '{1, 0, 0, 4'b0011, 4, 3, 2, o(1, 4'b0000, 0, S_PD)};
      vecs[14] = '{1, 0, 0, 4'b0011, 4, 3, 2, o(0, 4'b0000, 0, S_OFF)};

      for (int i = 0; i < 15; i++) begin
         set_in(vecs[i].rst, vecs[i].req, vecs[i].mask, int'(vecs[i].b), int'(vecs[i].c), int'(vecs[i].h));
         repeat (vecs[i].n) tick();
         check($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
      end

      // Sparse mask 1010: two rises, channels 0 and 2 untouched, ready 6 after bias.
      set_in(0, 1, 4'b1010, 2, 2, 3);
      bias_t = -1; ready_t = -1; stray = 0; prev = noise_on; hist.delete();
      for (int c = 0; c < 20; c++) begin
         tick();
         if (noisebias_on && bias_t < 0) bias_t = c;
         if (ready && ready_t < 0) ready_t = c;
         if ((noise_on & 4'b0101) != '0) stray++;
         if (noise_on != prev) hist.push_back(noise_on);
         prev = noise_on;
      end
      check("sparse_ready_lat", 32'(ready_t - bias_t), 32'd6);
      check("sparse_stray", 32'(stray), 32'd0);
      check("sparse_steps", 32'(hist.size()), 32'd2);
      if (hist.size() == 2) begin
         check("sparse_step0", 32'(hist[0]), 32'(4'b0010));
         check("sparse_step1", 32'(hist[1]), 32'(4'b1010));
      end

      // Hold expiry with hold 2: exactly one cycle of bias-only, then off.
      set_in(0, 0, 4'b1010, 2, 2, 2);
      pd_cycles = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (noisebias_on && noise_on == '0) pd_cycles++;
      end
      check("expiry_bias_only", 32'(pd_cycles), 32'd1);
      check("expiry_off", 32'(dut_out()), 32'(o(0, 4'b0000, 0, S_OFF)));

      // Abort in CH_WAIT.
      set_in(0, 1, 4'b1111, 2, 3, 2);
      seen = 0;
      repeat (4) begin tick(); if (ready) seen++; end
      check("abort_in_chwait", 32'(state), 32'(S_CW));
      req = 1'b0;
      tick(); if (ready) seen++;
      check("abort_pwrdn", 32'(dut_out()), 32'(o(1, 4'b0000, 0, S_PD)));
      tick(); if (ready) seen++;
      check("abort_off", 32'(dut_out()), 32'(o(0, 4'b0000, 0, S_OFF)));
      check("abort_no_ready", 32'(seen), 32'd0);

      // Zero mask never leaves OFF.
      set_in(0, 1, 4'b0000, 2, 3, 2);
      seen = 0;
      repeat (20) begin tick(); if (busy) seen++; end
      check("zero_mask_busy", 32'(seen), 32'd0);

      // Reset mid-RUN, then full restart.
      set_in(0, 1, 4'b0011, 3, 1, 2);
      got = 0;
      for (int c = 0; c < 50 && !got; c++) begin tick(); if (ready) got = 1; end
      check("rst_reach_run", 32'(got), 32'd1);
      rst = 1'b1;
      tick();
      check("rst_outputs", 32'(dut_out()), 32'd0);
      rst = 1'b0;
      bias_t = -1; ready_t = -1;
      for (int c = 0; c < 30 && ready_t < 0; c++) begin
         tick();
         if (noisebias_on && bias_t < 0) bias_t = c;
         if (ready && ready_t < 0) ready_t = c;
      end
      check("rst_restart_lat", 32'(ready_t - bias_t), 32'd5);

      // Randomized run against the model.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 9) == 0) req = ~req;
         if ($urandom_range(0, 3) == 0) ena_mask = NCH'($urandom_range(0, 15));
         bias_settle = SW'($urandom_range(0, 4));
         ch_settle   = SW'($urandom_range(0, 4));
         hold_cycles = SW'($urandom_range(0, 6));
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
